// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle: fetch/data requester lines plus the MFA/MFC bus.
// The slave modport is the arbiter side; master is requesters plus memory.
interface mem_port_arbiter_if;
  logic        F_REQ;
  logic [31:0] F_ADDR;
  logic        D_REQ;
  logic        D_RW;
  logic        D_WB;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        F_DONE;
  logic        D_DONE;
  logic        F_GNT;
  logic        D_GNT;
  logic [31:0] RDATA;
  logic        ERR;
  logic [31:0] MEMADD;
  logic [31:0] MEMDAT_OUT;
  logic [31:0] MEMDAT_IN;
  logic        MFA;
  logic        MFC;
  logic        READ_WRITE;
  logic        WORD_BYTE;

  modport slave (
    input  F_REQ, F_ADDR, D_REQ, D_RW, D_WB,
    input  D_ADDR, D_WDATA, MEMDAT_IN, MFC,
    output F_DONE, D_DONE, F_GNT, D_GNT,
    output RDATA, ERR, MEMADD, MEMDAT_OUT,
    output MFA, READ_WRITE, WORD_BYTE
  );

  modport master (
    output F_REQ, F_ADDR, D_REQ, D_RW, D_WB,
    output D_ADDR, D_WDATA, MEMDAT_IN, MFC,
    input  F_DONE, D_DONE, F_GNT, D_GNT,
    input  RDATA, ERR, MEMADD, MEMDAT_OUT,
    input  MFA, READ_WRITE, WORD_BYTE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and MFA/MFC sequencer for the single memory port.
// All outputs are registered; data wins unless fetch has been starved.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  localparam logic [7:0] TMO  = 8'(TIMEOUT);
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic        mfa, mfa_nxt;
  logic [31:0] memadd, memadd_nxt;
  logic [31:0] memdat, memdat_nxt;
  logic        rw, rw_nxt;
  logic        wb, wb_nxt;
  logic [31:0] rdata, rdata_nxt;
  logic        f_done, f_done_nxt;
  logic        d_done, d_done_nxt;
  logic        f_gnt, f_gnt_nxt;
  logic        d_gnt, d_gnt_nxt;
  logic        err, err_nxt;
  logic [7:0]  tcnt, tcnt_nxt;
  logic [7:0]  scnt, scnt_nxt;
  logic        fetch_win;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      mfa    <= 1'b0;
      memadd <= '0;
      memdat <= '0;
      rw     <= 1'b1;
      wb     <= 1'b1;
      rdata  <= '0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      err    <= 1'b0;
      tcnt   <= '0;
      scnt   <= '0;
    end else begin
      state  <= state_nxt;
      mfa    <= mfa_nxt;
      memadd <= memadd_nxt;
      memdat <= memdat_nxt;
      rw     <= rw_nxt;
      wb     <= wb_nxt;
      rdata  <= rdata_nxt;
      f_done <= f_done_nxt;
      d_done <= d_done_nxt;
      f_gnt  <= f_gnt_nxt;
      d_gnt  <= d_gnt_nxt;
      err    <= err_nxt;
      tcnt   <= tcnt_nxt;
      scnt   <= scnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mfa_nxt    = mfa;
    memadd_nxt = memadd;
    memdat_nxt = memdat;
    rw_nxt     = rw;
    wb_nxt     = wb;
    rdata_nxt  = rdata;
    f_done_nxt = 1'b0;
    d_done_nxt = 1'b0;
    f_gnt_nxt  = f_gnt;
    d_gnt_nxt  = d_gnt;
    err_nxt    = 1'b0;
    tcnt_nxt   = tcnt;
    scnt_nxt   = scnt;
    fetch_win  = bus.F_REQ &&
                 (!bus.D_REQ || scnt == SLIM);

    unique case (state)
      IDLE: begin
        if (bus.F_REQ || bus.D_REQ) begin
          unique case (1'b1)
            fetch_win: begin
              memadd_nxt = bus.F_ADDR;
              rw_nxt     = 1'b1;
              wb_nxt     = 1'b1;
              f_gnt_nxt  = 1'b1;
              d_gnt_nxt  = 1'b0;
              scnt_nxt   = '0;
            end
            !fetch_win: begin
              memadd_nxt = bus.D_ADDR;
              memdat_nxt = bus.D_WDATA;
              rw_nxt     = bus.D_RW;
              wb_nxt     = bus.D_WB;
              f_gnt_nxt  = 1'b0;
              d_gnt_nxt  = 1'b1;
              scnt_nxt   = bus.F_REQ ?
                           scnt + 8'd1 : '0;
            end
          endcase
          tcnt_nxt  = '0;
          mfa_nxt   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // MFC is checked first so a late ack on the last cycle still wins
        if (bus.MFC) begin
          if (rw)
            rdata_nxt = wb ? bus.MEMDAT_IN :
                        {24'b0, bus.MEMDAT_IN[7:0]};
          mfa_nxt    = 1'b0;
          f_done_nxt = f_gnt;
          d_done_nxt = d_gnt;
          state_nxt  = RELEASE;
        end else if (tcnt == TMO) begin
          mfa_nxt    = 1'b0;
          f_done_nxt = f_gnt;
          d_done_nxt = d_gnt;
          err_nxt    = 1'b1;
          state_nxt  = RELEASE;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      RELEASE: begin
        if (!bus.MFC) begin
          f_gnt_nxt = 1'b0;
          d_gnt_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.MFA        = mfa;
  assign bus.MEMADD     = memadd;
  assign bus.MEMDAT_OUT = memdat;
  assign bus.READ_WRITE = rw;
  assign bus.WORD_BYTE  = wb;
  assign bus.RDATA      = rdata;
  assign bus.F_DONE     = f_done;
  assign bus.D_DONE     = d_done;
  assign bus.F_GNT      = f_gnt;
  assign bus.D_GNT      = d_gnt;
  assign bus.ERR        = err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a memory
// model answering MFA with MFC, and a monitor checking every DONE.
module tb_mem_port_arbiter;

  typedef struct {
    bit          fetch;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] addr;
    bit          rw;
    bit          wb;
    bit          chk_wd;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic mfa_q = 1'b0;
  exp_t sb[$];

  int          mfc_delay = 0;
  int          mfc_hold = 0;
  bit          mem_mute = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          dly_cnt = 0;
  int          hold_cnt = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT     (255),
    .STARVE_LIMIT(4)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input bit f, input logic [31:0] a,
                      input bit rw, input bit wb,
                      input bit cwd, input logic [31:0] wd,
                      input logic [31:0] rd, input bit er,
                      input int lat);
    exp_t e;
    e.fetch  = f;
    e.addr   = a;
    e.rw     = rw;
    e.wb     = wb;
    e.chk_wd = cwd;
    e.wdata  = wd;
    e.rdata  = rd;
    e.err    = er;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  // Memory: ack after mfc_delay cycles, release mfc_hold cycles late
  initial begin
    bus.MFC       = 1'b0;
    bus.MEMDAT_IN = '0;
    forever begin
      @(negedge clk);
      if (bus.MFA) begin
        hold_cnt = 0;
        if (!bus.MFC && !mem_mute) begin
          if (dly_cnt >= mfc_delay) begin
            bus.MEMDAT_IN = mem_rdata;
            bus.MFC       = 1'b1;
          end else begin
            dly_cnt++;
          end
        end
      end else begin
        dly_cnt = 0;
        if (bus.MFC) begin
          if (hold_cnt >= mfc_hold) bus.MFC = 1'b0;
          else hold_cnt++;
        end
      end
    end
  end

  // Monitor: pops one expectation per DONE pulse
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.MFA && !mfa_q) rise_cyc = cyc;
    mfa_q = bus.MFA;
    if (bus.F_DONE || bus.D_DONE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got F=%b D=%b expected none",
                 bus.F_DONE, bus.D_DONE);
      end else begin
        e = sb.pop_front();
        chk("f_done", 32'(bus.F_DONE), 32'(e.fetch));
        chk("d_done", 32'(bus.D_DONE), 32'(!e.fetch));
        chk("gnt", 32'({bus.F_GNT, bus.D_GNT}),
            e.fetch ? 32'd2 : 32'd1);
        chk("err", 32'(bus.ERR), 32'(e.err));
        chk("rdata", bus.RDATA, e.rdata);
        chk("memadd", bus.MEMADD, e.addr);
        chk("read_write", 32'(bus.READ_WRITE), 32'(e.rw));
        chk("word_byte", 32'(bus.WORD_BYTE), 32'(e.wb));
        if (e.chk_wd) chk("memdat_out", bus.MEMDAT_OUT, e.wdata);
        chk("latency", 32'(cyc - rise_cyc), 32'(e.lat));
      end
    end
  end

  task automatic wait_done(input bit fetch, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fetch ? bus.F_DONE : bus.D_DONE) && n < 1000);
    if (!(fetch ? bus.F_DONE : bus.D_DONE)) begin
      checks++;
      errors++;
      $display("FAIL %s: got no DONE expected DONE within 1000 cycles",
               nm);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input string nm);
    bus.F_ADDR = a;
    bus.F_REQ  = 1'b1;
    wait_done(1'b1, nm);
    @(posedge clk);
    #1 bus.F_REQ = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input bit rw,
                         input bit wb, input logic [31:0] wd,
                         input string nm);
    bus.D_ADDR  = a;
    bus.D_RW    = rw;
    bus.D_WB    = wb;
    bus.D_WDATA = wd;
    bus.D_REQ   = 1'b1;
    wait_done(1'b0, nm);
    @(posedge clk);
    #1 bus.D_REQ = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_mfa", 32'(bus.MFA), 32'd0);
    chk("rst_memadd", bus.MEMADD, 32'd0);
    chk("rst_memdat_out", bus.MEMDAT_OUT, 32'd0);
    chk("rst_read_write", 32'(bus.READ_WRITE), 32'd1);
    chk("rst_word_byte", 32'(bus.WORD_BYTE), 32'd1);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_done", 32'({bus.F_DONE, bus.D_DONE}), 32'd0);
    chk("rst_gnt", 32'({bus.F_GNT, bus.D_GNT}), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    rst_n       = 1'b0;
    bus.F_REQ   = 1'b0;
    bus.F_ADDR  = '0;
    bus.D_REQ   = 1'b0;
    bus.D_RW    = 1'b1;
    bus.D_WB    = 1'b1;
    bus.D_ADDR  = '0;
    bus.D_WDATA = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Reset in the middle of an access must drop MFA at once
    mem_mute   = 1'b1;
    bus.F_ADDR = 32'h80;
    bus.F_REQ  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.MFA && n < 20);
    chk("mid_access_mfa_up", 32'(bus.MFA), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_mfa", 32'(bus.MFA), 32'd0);
    bus.F_REQ = 1'b0;
    mem_mute  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();

    // Fetch word read, MFC after two cycles
    mfc_delay = 2;
    mem_rdata = 32'hE3A01005;
    push(1, 32'h100, 1, 1, 0, '0, 32'hE3A01005, 0, 3);
    do_fetch(32'h100, "fetch_word");
    mfc_delay = 0;

    // Byte read then byte write
    mem_rdata = 32'hAABBCCDD;
    push(0, 32'h203, 1, 0, 0, '0, 32'h000000DD, 0, 1);
    do_data(32'h203, 1'b1, 1'b0, 32'h0, "byte_read");
    push(0, 32'h204, 0, 0, 1, 32'h55, 32'h000000DD, 0, 1);
    do_data(32'h204, 1'b0, 1'b0, 32'h55, "byte_write");

    // Both requests held: D,D,D,D,F repeating
    mem_rdata = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4)
        push(1, 32'h1000, 1, 1, 0, '0, 32'h12345678, 0, 1);
      else
        push(0, 32'h2000, 1, 1, 0, '0, 32'h12345678, 0, 1);
    end
    bus.F_ADDR  = 32'h1000;
    bus.D_ADDR  = 32'h2000;
    bus.D_RW    = 1'b1;
    bus.D_WB    = 1'b1;
    bus.F_REQ   = 1'b1;
    bus.D_REQ   = 1'b1;
    n = 0;
    k = 0;
    while (n < 10 && k < 300) begin
      @(negedge clk);
      k++;
      if (bus.F_DONE || bus.D_DONE) n++;
    end
    if (n < 10) begin
      checks++;
      errors++;
      $display("FAIL starve_seq: got %0d DONEs expected 10", n);
    end
    @(posedge clk);
    #1;
    bus.F_REQ = 1'b0;
    bus.D_REQ = 1'b0;

    // Memory silent: abort after TIMEOUT+1 cycles, RDATA kept
    mem_mute = 1'b1;
    push(0, 32'h300, 1, 1, 0, '0, 32'h12345678, 1, 256);
    do_data(32'h300, 1'b1, 1'b1, 32'h0, "timeout");
    mem_mute = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    push(1, 32'h400, 1, 1, 0, '0, 32'hCAFEF00D, 0, 1);
    do_fetch(32'h400, "after_timeout");

    // MFC held after the ack: no new MFA until it drops
    mfc_hold  = 5;
    mem_rdata = 32'h0BADCAFE;
    push(0, 32'h500, 0, 1, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0, 1);
    push(1, 32'h600, 1, 1, 0, '0, 32'h0BADCAFE, 0, 1);
    fork
      do_data(32'h500, 1'b0, 1'b1, 32'hDEADBEEF, "hold_write");
      do_fetch(32'h600, "hold_fetch");
      begin
        wait_done(1'b0, "hold_watch");
        repeat (4) begin
          @(negedge clk);
          chk("hold_no_mfa", 32'(bus.MFA), 32'd0);
          chk("hold_mfc_high", 32'(bus.MFC), 32'd1);
        end
      end
    join
    mfc_hold = 0;
    repeat (10) @(negedge clk);
    chk("end_mfc_low", 32'(bus.MFC), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
